top_level: RTL and testbench

TOP_LEVEL -- requirements
Module: top_level

---
 rtl/fec_pkg.sv | 39 +++
 rtl/top_level_data_mem.sv | 32 +++
 rtl/top_level.sv | 128 ++++++++++++
 tb/tb_top_level.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fec_pkg.sv
// ----------------------------------------------------------------------------
// fec_pkg
// Shared definitions for the Hamming(15,11) SECDED block encoder:
//   - controller state encoding
//   - default run geometry (message count, input/output base addresses)
//   - hamm_enc: pure function packing 11 data bits into a 16-bit codeword
// ----------------------------------------------------------------------------
package fec_pkg;

    localparam int NUM_MSG_DEF  = 15;
    localparam int IN_BASE_DEF  = 0;
    localparam int OUT_BASE_DEF = 30;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        RD_LO = 3'd2,
        RD_HI = 3'd3,
        WR_LO = 3'd4,
        WR_HI = 3'd5,
        FIN   = 3'd6
    } state_e;

    // d[0] is b1 ... d[10] is b11. Result bit k is Hamming position k, so the
    // data bits sit at the non-power-of-two positions and p0 at bit 0 makes
    // the whole 16-bit word even parity.
    function automatic logic [15:0] hamm_enc(input logic [10:0] d);
        logic        p0, p1, p2, p4, p8;
        logic [14:0] body;
        p8   = ^d[10:4];
        p4   = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[10];
        p2   = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[10];
        p1   = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10];
        body = {d[10:4], p8, d[3:1], p4, d[0], p2, p1};
        p0   = ^body;
        return {body, p0};
    endfunction

endpackage

// File: rtl/top_level_data_mem.sv
// ----------------------------------------------------------------------------
// data_mem
// 256 x 8 data memory, combinational read, synchronous write.
//   clk      : write clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address
//   rdata_o  : read data (combinational)
// ----------------------------------------------------------------------------
module data_mem (
    input  logic       clk,
    input  logic       we_i,
    input  logic [7:0] waddr_i,
    input  logic [7:0] wdata_i,
    input  logic [7:0] raddr_i,
    output logic [7:0] rdata_o
);

    logic [7:0] core [0:255];

    // NOTE: storage arrays get no reset; clearing 256 entries would need a
    // reset fan-out to every cell and the contents must survive a reset anyway.
    always_ff @(posedge clk) begin
        if (we_i) begin
            core[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = core[raddr_i];

endmodule

// File: rtl/top_level.sv
// ----------------------------------------------------------------------------
// top_level
// Reads NUM_MSG 11-bit messages from dm1 (two bytes each, starting at
// IN_BASE), Hamming(15,11) SECDED encodes them and writes the 16-bit
// codewords back to dm1 starting at OUT_BASE. Each message takes four
// cycles: read low, read high, write low, write high.
//   clk   : clock, rising edge
//   reset : asynchronous, active-low
//   start : run request; processing begins once it falls, and raising it
//           mid-run aborts back to ARMED
//   done  : high from the end of the last write until the next start
// ----------------------------------------------------------------------------
module top_level
    import fec_pkg::*;
#(
    parameter int NUM_MSG  = NUM_MSG_DEF,
    parameter int IN_BASE  = IN_BASE_DEF,
    parameter int OUT_BASE = OUT_BASE_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic done
);

    state_e     state_q, state_d;
    logic [6:0] cnt_q, cnt_d;
    logic [7:0] lo_q, lo_d;
    logic [2:0] hi_q, hi_d;
    logic       done_q, done_d;

    logic        mem_we;
    logic [7:0]  mem_waddr, mem_wdata, mem_raddr, mem_rdata;
    logic [7:0]  in_addr, out_addr;
    logic [15:0] code;

    // Byte addresses of the current message; 8-bit arithmetic, no wrap guard.
    assign in_addr  = 8'(IN_BASE)  + {cnt_q, 1'b0};
    assign out_addr = 8'(OUT_BASE) + {cnt_q, 1'b0};
    assign code     = hamm_enc({hi_q, lo_q});

    // NOTE: every signal driven here gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        mem_we    = 1'b0;
        mem_raddr = in_addr;
        mem_waddr = out_addr;
        mem_wdata = code[7:0];

        case (state_q)
            IDLE: begin
                if (start) state_d = ARMED;
            end
            ARMED: begin
                cnt_d = '0;
                if (!start) state_d = RD_LO;
            end
            RD_LO: begin
                lo_d    = mem_rdata;
                state_d = RD_HI;
            end
            RD_HI: begin
                mem_raddr = in_addr + 8'd1;
                hi_d      = mem_rdata[2:0];
                state_d   = WR_LO;
            end
            WR_LO: begin
                mem_we  = 1'b1;
                state_d = WR_HI;
            end
            WR_HI: begin
                mem_we    = 1'b1;
                mem_waddr = out_addr + 8'd1;
                mem_wdata = code[15:8];
                cnt_d     = cnt_q + 7'd1;
                state_d   = (cnt_q == 7'(NUM_MSG - 1)) ? FIN : RD_LO;
            end
            FIN: begin
                if (start) state_d = ARMED;
            end
            default: state_d = IDLE;
        endcase

        // A start during processing aborts the run; the pending write is
        // dropped so the abort takes effect on the same edge.
        if (start && (state_q == RD_LO || state_q == RD_HI ||
                      state_q == WR_LO || state_q == WR_HI)) begin
            state_d = ARMED;
            mem_we  = 1'b0;
        end

        done_d = (state_d == FIN);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            done_q  <= done_d;
        end
    end

    assign done = done_q;

    data_mem dm1 (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (mem_wdata),
        .raddr_i (mem_raddr),
        .rdata_o (mem_rdata)
    );

endmodule

// File: tb/tb_top_level.sv
// ----------------------------------------------------------------------------
// tb_top_level
// Directed bench for top_level: hand-computed codewords for the corner
// vectors, an independent positional Hamming model for random data, done
// latency, FIN hold, abort and mid-run reset behaviour.
// ----------------------------------------------------------------------------
module tb_top_level;
    import fec_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] in_lo [15];
    logic [7:0] in_hi [15];
    logic [7:0] snap  [30];

    top_level #(.NUM_MSG(15), .IN_BASE(0), .OUT_BASE(30)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Codeword bit k = Hamming position k; data fills positions that are not
    // powers of two, parity p(2^j) covers positions with bit j set, bit 0
    // gives even overall parity.
    function automatic logic [15:0] ref_enc(input logic [10:0] d);
        logic [15:0] w;
        int          k;
        w = '0;
        k = 0;
        for (int pos = 1; pos < 16; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                w[pos] = d[k];
                k++;
            end
        end
        for (int j = 0; j < 4; j++) begin
            logic p;
            p = 1'b0;
            for (int pos = 1; pos < 16; pos++) begin
                if (pos[j]) p ^= w[pos];
            end
            w[1 << j] = p;
        end
        w[0] = ^w[15:1];
        return w;
    endfunction

    task automatic load_inputs();
        for (int i = 0; i < 15; i++) begin
            dut.dm1.core[2*i]   = in_lo[i];
            dut.dm1.core[2*i+1] = in_hi[i];
        end
    endtask

    task automatic fill_outputs(input logic [7:0] v);
        for (int i = 30; i < 60; i++) dut.dm1.core[i] = v;
    endtask

    task automatic set_single(input logic [7:0] lo, input logic [7:0] hi);
        for (int i = 0; i < 15; i++) begin
            in_lo[i] = 8'h00;
            in_hi[i] = 8'h00;
        end
        in_lo[0] = lo;
        in_hi[0] = hi;
    endtask

    task automatic set_random();
        for (int i = 0; i < 15; i++) begin
            in_lo[i] = 8'($urandom);
            in_hi[i] = 8'($urandom);
        end
    endtask

    // Pulse start; returns just after the edge on which the FSM leaves ARMED.
    task automatic start_run();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        @(posedge clk);
    endtask

    // Counts edges after leaving ARMED until done is seen high (bounded).
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
            if (done) break;
        end
    endtask

    task automatic check_all(input string tag);
        logic [15:0] e;
        for (int i = 0; i < 15; i++) begin
            e = ref_enc({in_hi[i][2:0], in_lo[i]});
            check($sformatf("%s_lo%0d", tag, i), 32'(dut.dm1.core[30+2*i]),   32'(e[7:0]));
            check($sformatf("%s_hi%0d", tag, i), 32'(dut.dm1.core[30+2*i+1]), 32'(e[15:8]));
        end
    endtask

    task automatic directed(input string tag, input logic [7:0] lo, input logic [7:0] hi,
                            input logic [7:0] exp_lo, input logic [7:0] exp_hi);
        int cyc;
        set_single(lo, hi);
        load_inputs();
        fill_outputs(8'h5A);
        start_run();
        wait_done(cyc);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_lo"}, 32'(dut.dm1.core[30]), 32'(exp_lo));
        check({tag, "_hi"}, 32'(dut.dm1.core[31]), 32'(exp_hi));
    endtask

    initial begin
        int          cyc;
        int          diffs;
        logic [15:0] e;

        reset = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 256; i++) dut.dm1.core[i] = 8'h00;
        fill_outputs(8'hA5);
        repeat (2) @(negedge clk);
        check("rst_done",  32'(done), 32'd0);
        check("rst_state", 32'(dut.state_q), 32'(IDLE));
        check("rst_cnt",   32'(dut.cnt_q), 32'd0);
        reset = 1'b1;

        // Nothing may be written before a start pulse.
        repeat (6) @(negedge clk);
        check("idle_nowrite_lo", 32'(dut.dm1.core[30]), 32'hA5);
        check("idle_nowrite_hi", 32'(dut.dm1.core[31]), 32'hA5);
        check("idle_done",       32'(done), 32'd0);

        // While start is held, FSM sits in ARMED with done low.
        @(negedge clk) start = 1'b1;
        repeat (3) @(negedge clk);
        check("armed_state", 32'(dut.state_q), 32'(ARMED));
        check("armed_done",  32'(done), 32'd0);
        start = 1'b0;
        wait_done(cyc);

        directed("vec_9f06", 8'b10011111, 8'b00000110, 8'b11101110, 8'b11010010);
        directed("vec_zero", 8'h00, 8'h00, 8'h00, 8'h00);
        directed("vec_ff07", 8'hFF, 8'h07, 8'hFF, 8'hFF);
        directed("vec_ffff", 8'hFF, 8'hFF, 8'hFF, 8'hFF);

        // Single b1 plus exact done latency: 4 cycles per message after ARMED.
        set_single(8'h01, 8'h00);
        load_inputs();
        start_run();
        wait_done(cyc);
        check("lat_done_cycles", 32'(cyc), 32'd60);
        check("vec_01_lo", 32'(dut.dm1.core[30]), 32'h0F);
        check("vec_01_hi", 32'(dut.dm1.core[31]), 32'h00);

        // Random messages against the model; done held in FIN.
        set_random();
        load_inputs();
        start_run();
        wait_done(cyc);
        check("rand_done", 32'(done), 32'd1);
        check_all("rand");
        repeat (20) @(negedge clk);
        check("fin_hold_done",  32'(done), 32'd1);
        check("fin_hold_state", 32'(dut.state_q), 32'(FIN));
        @(negedge clk) start = 1'b1;
        @(negedge clk);
        check("fin_clear_done",  32'(done), 32'd0);
        check("fin_clear_state", 32'(dut.state_q), 32'(ARMED));
        start = 1'b0;
        wait_done(cyc);

        // Abort mid-run, then the restarted run completes correctly.
        set_random();
        load_inputs();
        fill_outputs(8'hA5);
        start_run();
        repeat (6) @(posedge clk);
        @(negedge clk) start = 1'b1;
        @(negedge clk);
        check("abort_state", 32'(dut.state_q), 32'(ARMED));
        check("abort_done",  32'(done), 32'd0);
        start = 1'b0;
        wait_done(cyc);
        check("abort_rerun_cycles", 32'(cyc), 32'd61);
        check_all("abort_rerun");

        // Reset ten cycles into a run: immediate IDLE, no further writes.
        set_random();
        load_inputs();
        fill_outputs(8'hA5);
        start_run();
        repeat (10) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("midrst_done",  32'(done), 32'd0);
        check("midrst_state", 32'(dut.state_q), 32'(IDLE));
        for (int i = 0; i < 30; i++) snap[i] = dut.dm1.core[30+i];
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        diffs = 0;
        for (int i = 0; i < 30; i++) if (dut.dm1.core[30+i] !== snap[i]) diffs++;
        check("midrst_nowrite", 32'(diffs), 32'd0);
        e = ref_enc({in_hi[1][2:0], in_lo[1]});
        check("midrst_kept_hi1", 32'(dut.dm1.core[33]), 32'(e[15:8]));
        check("midrst_unwritten", 32'(dut.dm1.core[34]), 32'hA5);
        check("midrst_idle", 32'(dut.state_q), 32'(IDLE));
        start_run();
        wait_done(cyc);
        check("postrst_done", 32'(done), 32'd1);
        check_all("postrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
